// File: rtl/cpu_dpi_server_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dpi_server_rx: polls N_CPUS clients, buffers per client, drains RR   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module cpu_dpi_server_rx #(
  parameter int N_CPUS     = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int IDX_W     = (N_CPUS > 1) ? $clog2(N_CPUS) : 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              server_en,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_cpu_idx,
  output logic [N_CPUS-1:0] fifo_full,
  output logic [31:0]       rx_count,
  // get_data binding: dpi_req high means a call for client dpi_idx this cycle;
  // the binding answers on dpi_ok/dpi_data and dequeues at the clock edge
  output logic              dpi_req,
  output logic [IDX_W-1:0]  dpi_idx,
  input  logic              dpi_ok,
  input  logic [DATA_W-1:0] dpi_data
);
  localparam int               ADDR_W   = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CPUS - 1);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [N_CPUS][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_CPUS];
  logic [PTR_W-1:0]  wr_ptr_d [N_CPUS];
  logic [PTR_W-1:0]  rd_ptr_q [N_CPUS];
  logic [PTR_W-1:0]  rd_ptr_d [N_CPUS];
  logic [N_CPUS-1:0] fifo_full_q, fifo_full_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_cpu_idx_q, out_cpu_idx_d;
  logic [31:0]       rx_count_q, rx_count_d;
  logic [IDX_W-1:0]  poll_idx_q, poll_idx_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_CPUS-1:0] empty_w, full_w, push_w, pop_w;
  logic [IDX_W-1:0]  grant_w;
  logic              any_w;

  always_comb begin
    for (int i = 0; i < N_CPUS; i++) begin
      empty_w[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_w[i]  = ((wr_ptr_q[i] - rd_ptr_q[i]) == DEPTH_C);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping at N_CPUS
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    grant_w = '0;
    any_w   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N_CPUS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_CPUS) j = j - N_CPUS;
      jj = IDX_W'(j);
      if (!any_w && !empty_w[jj]) begin
        any_w   = 1'b1;
        grant_w = jj;
      end
    end
  end

  always_comb begin
    out_vld_d     = out_vld_q;
    out_data_d    = out_data_q;
    out_cpu_idx_d = out_cpu_idx_q;
    rx_count_d    = rx_count_q;
    poll_idx_d    = poll_idx_q;
    rr_ptr_d      = rr_ptr_q;
    push_w        = '0;
    pop_w         = '0;
    fifo_full_d   = '0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    // Poll gated by pre-edge fullness only; a same-cycle pop does not help it
    dpi_req = rst_n && server_en && !full_w[poll_idx_q];
    if (dpi_req && dpi_ok) push_w[poll_idx_q] = 1'b1;
    if (server_en) poll_idx_d = next_idx(poll_idx_q);

    if (!out_vld_q || out_rdy) begin
      if (any_w) begin
        pop_w[grant_w] = 1'b1;
        out_data_d     = mem_q[grant_w][rd_ptr_q[grant_w][ADDR_W-1:0]];
        out_cpu_idx_d  = grant_w;
        out_vld_d      = 1'b1;
        rr_ptr_d       = next_idx(grant_w);
      end else if (out_rdy) begin
        out_vld_d = 1'b0;
      end
    end

    if (out_vld_q && out_rdy) rx_count_d = rx_count_q + 32'd1;

    for (int i = 0; i < N_CPUS; i++) begin
      wr_ptr_d[i]    = wr_ptr_q[i] + PTR_W'(push_w[i]);
      rd_ptr_d[i]    = rd_ptr_q[i] + PTR_W'(pop_w[i]);
      fifo_full_d[i] = ((wr_ptr_d[i] - rd_ptr_d[i]) == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CPUS; i++) begin
      if (push_w[i]) mem_q[i][wr_ptr_q[i][ADDR_W-1:0]] <= dpi_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CPUS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      fifo_full_q   <= '0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_cpu_idx_q <= '0;
      rx_count_q    <= '0;
      poll_idx_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_full_q   <= fifo_full_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      out_cpu_idx_q <= out_cpu_idx_d;
      rx_count_q    <= rx_count_d;
      poll_idx_q    <= poll_idx_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_cpu_idx = out_cpu_idx_q;
  assign fifo_full   = fifo_full_q;
  assign rx_count    = rx_count_q;
  assign dpi_idx     = poll_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dpi_server_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_dpi_server_rx: random stimulus vs queue-level reference model      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_cpu_dpi_server_rx;
  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        server_en = 1'b0, out_rdy = 1'b0;
  logic        out_vld;
  logic [63:0] out_data;
  logic [1:0]  out_cpu_idx;
  logic [3:0]  fifo_full;
  logic [31:0] rx_count;
  logic        dpi_req;
  logic [1:0]  dpi_idx;
  logic        dpi_ok = 1'b0;
  logic [63:0] dpi_data = '0;

  logic        server_en1 = 1'b0, out_rdy1 = 1'b1;
  logic        out_vld1;
  logic [63:0] out_data1;
  logic        out_cpu_idx1;
  logic        fifo_full1;
  logic [31:0] rx_count1;
  logic        dpi_req1;
  logic        dpi_idx1;
  logic        dpi_ok1 = 1'b0;
  logic [63:0] dpi_data1 = '0;

  cpu_dpi_server_rx #(.N_CPUS(N), .DATA_W(64), .FIFO_DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .server_en(server_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_cpu_idx(out_cpu_idx), .fifo_full(fifo_full), .rx_count(rx_count),
    .dpi_req(dpi_req), .dpi_idx(dpi_idx), .dpi_ok(dpi_ok), .dpi_data(dpi_data)
  );

  cpu_dpi_server_rx #(.N_CPUS(1), .DATA_W(64), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .server_en(server_en1),
    .out_vld(out_vld1), .out_rdy(out_rdy1), .out_data(out_data1),
    .out_cpu_idx(out_cpu_idx1), .fifo_full(fifo_full1), .rx_count(rx_count1),
    .dpi_req(dpi_req1), .dpi_idx(dpi_idx1), .dpi_ok(dpi_ok1), .dpi_data(dpi_data1)
  );

  always #5 clk = ~clk;

  // Client send queues (the DPI side) and the reference model of the server
  logic [63:0] dq [N][$];
  logic [63:0] mf [N][$];
  int          m_pidx, m_rr, m_oc;
  bit          m_ov;
  logic [63:0] m_od;
  logic [31:0] m_rx;

  int n_tests = 0, n_fail = 0, dut_calls = 0;
  int hs_cpu[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) mf[c].delete();
    m_pidx = 0; m_rr = 0; m_oc = 0; m_ov = 0; m_od = '0; m_rx = '0;
  endtask

  task automatic model_step();
    bit fpre;
    int g;
    int j;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fpre = (mf[m_pidx].size() >= D);
    if (m_ov && out_rdy) m_rx++;
    if (!m_ov || out_rdy) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && mf[j].size() > 0) g = j;
      end
      if (g >= 0) begin
        m_od = mf[g].pop_front();
        m_oc = g; m_ov = 1'b1; m_rr = (g + 1) % N;
      end else if (out_rdy) begin
        m_ov = 1'b0;
      end
    end
    if (server_en) begin
      if (!fpre && dq[m_pidx].size() > 0) mf[m_pidx].push_back(dq[m_pidx].pop_front());
      m_pidx = (m_pidx + 1) % N;
    end
  endtask

  task automatic tick(input bit rdy, input bit en);
    logic [3:0] eff;
    out_rdy   = rdy;
    server_en = en;
    dpi_ok    = (dq[dpi_idx].size() > 0);
    dpi_data  = dpi_ok ? dq[dpi_idx][0] : 64'h0;
    #1;
    chk("dpi_req", dpi_req, rst_n && en && (mf[m_pidx].size() < D));
    chk("dpi_idx", dpi_idx, m_pidx);
    if (dpi_req) dut_calls++;
    if (out_vld && out_rdy) hs_cpu.push_back(int'(out_cpu_idx));
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < N; c++) eff[c] = (mf[c].size() == D);
    chk("out_vld", out_vld, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_cpu_idx", out_cpu_idx, m_oc);
    chk("fifo_full", fifo_full, eff);
    chk("rx_count", rx_count, m_rx);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_cpu_idx, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_rx", rx_count, 0);
    chk("rst_req", dpi_req, 0);
    model_reset();
    @(negedge clk);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int rx0, calls0, sent, got, c;
    bit take;
    logic [63:0] w;
    logic [63:0] exp1[$];
    logic [63:0] dq1[$];

    model_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // Single client 1, three words
    for (int i = 1; i <= 3; i++) dq[1].push_back(64'hA5A5_0000_0000_0000 | 64'(i));
    hs_cpu.delete();
    repeat (12) tick(1'b1, 1'b1);
    chk("t2_rx", rx_count, 3);
    chk("t2_n", hs_cpu.size(), 3);
    foreach (hs_cpu[i]) chk("t2_cpu", hs_cpu[i], 1);

    // Two words per client buffered, then drained round-robin
    do_reset();
    for (int k = 0; k < N; k++) begin
      dq[k].push_back({$urandom, $urandom});
      dq[k].push_back({$urandom, $urandom});
    end
    repeat (12) tick(1'b0, 1'b1);
    hs_cpu.delete();
    rx0 = int'(rx_count);
    repeat (12) tick(1'b1, 1'b1);
    chk("t3_rx", int'(rx_count) - rx0, 8);
    chk("t3_n", hs_cpu.size(), 8);
    foreach (hs_cpu[i]) chk("t3_order", hs_cpu[i], i % N);

    // Back-pressure fills client 0
    for (int i = 0; i < 6; i++) dq[0].push_back({$urandom, $urandom});
    repeat (20) tick(1'b0, 1'b1);
    chk("t4_full0", fifo_full[0], 1);
    hs_cpu.delete();
    repeat (15) tick(1'b1, 1'b1);
    chk("t4_n", hs_cpu.size(), 6);

    // Polling disabled with pending client data
    for (int i = 0; i < 3; i++) dq[2].push_back({$urandom, $urandom});
    calls0 = dut_calls;
    repeat (10) tick(1'b1, 1'b0);
    chk("t5_calls", dut_calls - calls0, 0);
    chk("t5_vld", out_vld, 0);
    repeat (10) tick(1'b1, 1'b1);

    // Random traffic
    repeat (300) begin
      if ($urandom_range(0, 9) < 4) begin
        c = $urandom_range(0, N - 1);
        dq[c].push_back({$urandom, $urandom});
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9);
    end

    // Reset while words are buffered
    for (int k = 0; k < N; k++) repeat (3) dq[k].push_back({$urandom, $urandom});
    repeat (6) tick(1'b0, 1'b1);
    calls0 = dut_calls;
    do_reset();
    chk("rst_calls", dut_calls - calls0, 0);
    repeat (30) tick(1'b1, 1'b1);

    // N_CPUS=1, FIFO_DEPTH=2: push and pop on a full FIFO, scoreboard
    server_en = 1'b0;
    server_en1 = 1'b1;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
      if (sent < 100 && $urandom_range(0, 9) < 7) begin
        w = {$urandom, $urandom};
        dq1.push_back(w);
        exp1.push_back(w);
        sent++;
      end
      out_rdy1  = (sent >= 100) ? 1'b1 : ($urandom_range(0, 1) == 1);
      dpi_ok1   = (dq1.size() > 0);
      dpi_data1 = dpi_ok1 ? dq1[0] : 64'h0;
      #1;
      take = dpi_req1 && dpi_ok1;
      if (out_vld1 && out_rdy1) begin
        if (exp1.size() > 0) chk("t6_data", out_data1, exp1.pop_front());
        else chk("t6_spurious", out_vld1, 0);
        got++;
      end
      @(posedge clk);
      if (take) void'(dq1.pop_front());
      @(negedge clk);
    end
    chk("t6_got", got, 100);
    chk("t6_left", exp1.size(), 0);
    chk("t6_rx", rx_count1, 100);
    chk("t6_idx", out_cpu_idx1, 0);
    chk("t6_pidx", dpi_idx1, 0);
    chk("t6_full", fifo_full1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
